// File: rtl/multicycle_seq_pkg.sv
// Shared types for the LEGv8-subset multi-cycle sequencer: opcodes, FSM states, strobe bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    PC_INIT = 4'd0, ADDI = 4'd1, ADDS = 4'd2, BLT  = 4'd3, B    = 4'd4,
    CBZ     = 4'd5, LDUR = 4'd6, LSL  = 4'd7, LSR  = 4'd8, MUL  = 4'd9,
    STUR    = 4'd10, SUBS = 4'd11, INV = 4'd12
  } opcode_e;

  // State literals carry an S_ prefix so they do not collide with opcode MUL.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MUL = 3'd3,
    S_MEM   = 3'd4, S_WB     = 3'd5, S_HALT = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic imem_req;
    logic ir_load;
    logic pc_write;
    logic pc_src;
    logic flag_write;
    logic mul_start;
    logic dmem_req;
    logic dmem_we;
    logic reg_write;
    logic halted;
  } strobes_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Sequencer <-> datapath bundle. Perf counter signals exist only with CTRL_PERF_EN.
interface multicycle_seq_if #(parameter int CNT_W = 32);
  logic [3:0] opcode;
  logic       imem_ready, dmem_ready, zero_flag, lt_flag;
  logic       imem_req, ir_load, pc_write, pc_src, flag_write;
  logic       mul_start, dmem_req, dmem_we, reg_write, halted;
  logic [2:0] state_o;
`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] retired_cnt, stall_cnt;

  modport master (
    input  opcode, imem_ready, dmem_ready, zero_flag, lt_flag,
    output imem_req, ir_load, pc_write, pc_src, flag_write,
           mul_start, dmem_req, dmem_we, reg_write, halted, state_o,
           retired_cnt, stall_cnt
  );
  modport slave (
    output opcode, imem_ready, dmem_ready, zero_flag, lt_flag,
    input  imem_req, ir_load, pc_write, pc_src, flag_write,
           mul_start, dmem_req, dmem_we, reg_write, halted, state_o,
           retired_cnt, stall_cnt
  );
`else
  modport master (
    input  opcode, imem_ready, dmem_ready, zero_flag, lt_flag,
    output imem_req, ir_load, pc_write, pc_src, flag_write,
           mul_start, dmem_req, dmem_we, reg_write, halted, state_o
  );
  modport slave (
    output opcode, imem_ready, dmem_ready, zero_flag, lt_flag,
    input  imem_req, ir_load, pc_write, pc_src, flag_write,
           mul_start, dmem_req, dmem_we, reg_write, halted, state_o
  );
`endif
endinterface

// File: rtl/multicycle_seq_latency_ctr.sv
// Loadable down-counter with zero flag; sticks at zero rather than wrapping.
module seq_latency_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MUL/MEM/WB sequencer for the LEGv8-subset datapath.
// Optional perf counters (retired_cnt, stall_cnt) are built when CTRL_PERF_EN is defined.
module multicycle_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_seq_if.master  sq
);
  import ctrl_pkg::*;

  localparam int unsigned   CW       = cnt_width(MUL_CYCLES);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  seq_state_e    state, nxt;
  strobes_t      st, stv;
  opcode_e       op;
  logic [CW-1:0] mcnt;
  logic          mcnt_zero;

  assign op = opcode_e'(sq.opcode);

  seq_latency_ctr #(.W(CW)) u_mul_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == S_DECODE && nxt == S_MUL),
    .dec      (state == S_MUL),
    .load_val (MUL_LAST),
    .cnt      (mcnt),
    .zero     (mcnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    st  = '0;
    case (state)
      S_FETCH: begin
        st.imem_req = 1'b1;
        if (sq.imem_ready) begin
          st.ir_load = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == PC_INIT) begin
          st.pc_write = 1'b1;
          nxt         = S_FETCH;
        end
        else if (op >= INV) nxt = S_HALT;
        else if (op == MUL) nxt = S_MUL;
        else                nxt = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          ADDI, LSL, LSR: nxt = S_WB;
          ADDS, SUBS: begin
            st.flag_write = 1'b1;
            nxt           = S_WB;
          end
          LDUR, STUR: nxt = S_MEM;
          B, CBZ, BLT: begin
            st.pc_write = 1'b1;
            st.pc_src   = (op == B) ? 1'b1 : (op == CBZ) ? sq.zero_flag : sq.lt_flag;
            nxt         = S_FETCH;
          end
          default: nxt = S_HALT;
        endcase
      end
      S_MUL: begin
        // Counter only counts down, so the loaded value marks the entry cycle.
        st.mul_start = (mcnt == MUL_LAST);
        if (mcnt_zero) nxt = S_WB;
      end
      S_MEM: begin
        st.dmem_req = 1'b1;
        st.dmem_we  = (op == STUR);
        if (sq.dmem_ready) begin
          if (op == STUR) begin
            st.pc_write = 1'b1;
            nxt         = S_FETCH;
          end
          else nxt = S_WB;
        end
      end
      S_WB: begin
        st.reg_write = 1'b1;
        st.pc_write  = 1'b1;
        nxt          = S_FETCH;
      end
      S_HALT:  st.halted = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes must drop the moment reset asserts, even though FETCH requests imem.
  assign stv = reset_n ? st : '0;

  assign sq.imem_req   = stv.imem_req;
  assign sq.ir_load    = stv.ir_load;
  assign sq.pc_write   = stv.pc_write;
  assign sq.pc_src     = stv.pc_src;
  assign sq.flag_write = stv.flag_write;
  assign sq.mul_start  = stv.mul_start;
  assign sq.dmem_req   = stv.dmem_req;
  assign sq.dmem_we    = stv.dmem_we;
  assign sq.reg_write  = stv.reg_write;
  assign sq.halted     = stv.halted;
  assign sq.state_o    = state;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end
    else if (state != S_HALT) begin
      if (stv.pc_write) retired_q <= retired_q + 1'b1;
      if ((state == S_FETCH && !sq.imem_ready) || (state == S_MEM && !sq.dmem_ready))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign sq.retired_cnt = retired_q;
  assign sq.stall_cnt   = stall_q;
`endif

endmodule
